// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller: frame state
// encoding and the fixed line levels of a frame.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Bit selector for the data phase of a frame: a saturating bit counter over
// the latched frame data, presenting the current bit, the bit that follows it
// and a flag marking the last data bit.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] frame_data_i,
    output logic                  cur_bit_o,
    output logic                  next_bit_o,
    output logic                  done_o
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

    logic [CntW-1:0] bit_cnt_q;
    logic [CntW-1:0] next_idx;
    logic            done;

    // Last-bit flag and the saturated index of the bit that goes out next.
    always_comb begin
        done     = (bit_cnt_q == LastIdx);
        next_idx = done ? bit_cnt_q : bit_cnt_q + CntW'(1);
    end

    assign done_o     = done;
    assign cur_bit_o  = frame_data_i[bit_cnt_q];
    assign next_bit_o = frame_data_i[next_idx];

    // Counter is held at zero until the data phase and never wraps within a frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q <= '0;
        end else if (clear_i) begin
            bit_cnt_q <= '0;
        end else if (step_i && !done) begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: latches a byte on an accepted request and
// sends start bit, data bits LSB first, optional parity bit and stop bit,
// one bit per clock. All outputs come straight from registers.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_bit,
    output logic [DATA_WIDTH-1:0] Frame_Data,
    output logic                  PAR_Calc_en,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] frame_data_q;
    logic                  par_en_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  par_calc_en_q;

    logic ser_clear;
    logic ser_step;
    logic ser_cur_bit;
    logic ser_next_bit;
    logic ser_done;

    // Counter sits at zero through IDLE and START so bit 0 is ready for the START cycle.
    always_comb begin
        ser_clear = (state_q == StIdle) || (state_q == StStart);
        ser_step  = (state_q == StData);
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk_i        (CLK),
        .rst_i        (RST),
        .clear_i      (ser_clear),
        .step_i       (ser_step),
        .frame_data_i (frame_data_q),
        .cur_bit_o    (ser_cur_bit),
        .next_bit_o   (ser_next_bit),
        .done_o       (ser_done)
    );

    // Frame FSM; each branch also loads the line value of the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            frame_data_q  <= '0;
            par_en_q      <= 1'b0;
            tx_q          <= TX_IDLE_LEVEL;
            busy_q        <= 1'b0;
            par_calc_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q          <= TX_IDLE_LEVEL;
                    busy_q        <= 1'b0;
                    par_calc_en_q <= 1'b0;
                    if (Data_Valid) begin
                        state_q       <= StStart;
                        frame_data_q  <= P_DATA;
                        par_en_q      <= PAR_EN;
                        tx_q          <= START_BIT;
                        busy_q        <= 1'b1;
                        par_calc_en_q <= PAR_EN;
                    end
                end
                StStart: begin
                    state_q       <= StData;
                    tx_q          <= ser_cur_bit;
                    par_calc_en_q <= 1'b0;
                end
                StData: begin
                    if (!ser_done) begin
                        tx_q <= ser_next_bit;
                    end else if (par_en_q) begin
                        // Parity bit is captured as the line enters PARITY.
                        state_q <= StParity;
                        tx_q    <= PAR_bit;
                    end else begin
                        state_q <= StStop;
                        tx_q    <= STOP_BIT;
                    end
                end
                StParity: begin
                    state_q <= StStop;
                    tx_q    <= STOP_BIT;
                end
                StStop: begin
                    state_q <= StIdle;
                    tx_q    <= TX_IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q       <= StIdle;
                    tx_q          <= TX_IDLE_LEVEL;
                    busy_q        <= 1'b0;
                    par_calc_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign Frame_Data  = frame_data_q;
    assign PAR_Calc_en = par_calc_en_q;
    assign TX_OUT      = tx_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl. The stimulus side expands each
// accepted request into the list of per-cycle line values of a whole frame
// and feeds one expectation per cycle to a queue; the monitor compares.
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_bit;
    logic [DW-1:0] Frame_Data;
    logic          PAR_Calc_en;
    logic          TX_OUT;
    logic          Busy;

    uart_tx_frame_ctrl #(
        .DATA_WIDTH (DW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .PAR_EN      (PAR_EN),
        .PAR_bit     (PAR_bit),
        .Frame_Data  (Frame_Data),
        .PAR_Calc_en (PAR_Calc_en),
        .TX_OUT      (TX_OUT),
        .Busy        (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          tx;
        logic          busy;
        logic          pce;
        logic [DW-1:0] fd;
        bit            is_par;
    } exp_t;

    exp_t          pending[$];  // future cycles already decided by the model
    exp_t          sb[$];       // expectation for the cycle after the next edge
    logic [DW-1:0] fd_m;
    int            tests;
    int            fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic tx, input logic busy, input logic pce,
                                input logic [DW-1:0] fd, input bit is_par);
        exp_t e;
        e.tx = tx; e.busy = busy; e.pce = pce; e.fd = fd; e.is_par = is_par;
        return e;
    endfunction

    // Whole frame as seen on the line, plus the one mandatory idle cycle after STOP.
    task automatic build_frame(input logic [DW-1:0] d, input bit pe);
        fd_m = d;
        pending.push_back(mk(1'b0, 1'b1, pe, d, 1'b0));
        for (int i = 0; i < DW; i++) pending.push_back(mk(d[i], 1'b1, 1'b0, d, 1'b0));
        if (pe) pending.push_back(mk(1'b0, 1'b1, 1'b0, d, 1'b1));
        pending.push_back(mk(1'b1, 1'b1, 1'b0, d, 1'b0));
        pending.push_back(mk(1'b1, 1'b0, 1'b0, d, 1'b0));
    endtask

    // One bit period of stimulus; decides what the DUT must show after the next edge.
    task automatic step(input bit rst, input bit dv, input logic [DW-1:0] d, input bit pe,
                        input bit pb);
        exp_t it;
        @(negedge CLK);
        RST = rst; Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_bit = pb;
        if (rst) begin
            pending.delete();
            fd_m = '0;
            pending.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1'b0));
        end else if (pending.size() == 0) begin
            if (dv) build_frame(d, pe);
            else pending.push_back(mk(1'b1, 1'b0, 1'b0, fd_m, 1'b0));
        end
        it = pending.pop_front();
        if (it.is_par) it.tx = pb;  // parity bit is whatever is presented entering PARITY
        sb.push_back(it);
    endtask

    exp_t mon_it;
    always @(posedge CLK) begin
        #1;
        if (sb.size() > 0) begin
            mon_it = sb.pop_front();
            chk("tx_out", 32'(TX_OUT), 32'(mon_it.tx));
            chk("busy", 32'(Busy), 32'(mon_it.busy));
            chk("par_calc_en", 32'(PAR_Calc_en), 32'(mon_it.pce));
            chk("frame_data", 32'(Frame_Data), 32'(mon_it.fd));
        end
    end

    logic [DW-1:0] rd;
    initial begin
        tests = 0; fails = 0; fd_m = '0;
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_bit = 1'b0;

        // Reset then idle.
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h55, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 0);

        // 0xA5 with even parity, then without parity.
        step(0, 1, 8'hA5, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'hA5, 0, 1);
        for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1, 1);

        // Requests held high during a frame: only the post-STOP idle cycle may accept.
        step(0, 1, 8'hFF, 1, 0);
        for (int i = 0; i < 24; i++) step(0, 1, 8'h3C, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 0, 0);

        // Reset at data bit 4 of 0x0F, then a fresh frame.
        step(0, 1, 8'h0F, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'hC3, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 0, 0);

        // Reset coincident with a request: request is dropped.
        step(1, 1, 8'h99, 1, 1);
        step(0, 0, 8'h00, 0, 0);

        // Mid-frame toggling of PAR_EN, P_DATA and PAR_bit.
        step(0, 1, 8'h6B, 1, 0);
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            step(0, 0, rd, (i % 2) == 0, $urandom_range(0, 1) == 1);
        end

        // Random traffic with rare resets.
        for (int i = 0; i < 2500; i++) begin
            rd = 8'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, rd,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 14; i++) step(0, 0, 8'h00, 0, 0);

        @(posedge CLK);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
